// File: rtl/vga_rx_if.sv
// Signal bundle between a VGA source (timing generator or bench) and the receive-side monitor.
// The master drives the connector-side signals and probe coordinates; the slave reports results.
interface vga_rx_if;
  logic        p_tick;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic [9:0]  probe_x;
  logic [9:0]  probe_y;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        locked;
  logic        h_err;
  logic        v_err;
  logic [9:0]  h_total;
  logic [9:0]  v_total;
  logic [11:0] probe_rgb;
  logic        probe_vld;
  logic [31:0] frame_sum;
  logic        frame_done;

  modport master (
    output p_tick, hsync, vsync, rgb, probe_x, probe_y,
    input  x, y, video_on, locked, h_err, v_err, h_total, v_total,
    input  probe_rgb, probe_vld, frame_sum, frame_done
  );

  modport slave (
    input  p_tick, hsync, vsync, rgb, probe_x, probe_y,
    output x, y, video_on, locked, h_err, v_err, h_total, v_total,
    output probe_rgb, probe_vld, frame_sum, frame_done
  );
endinterface

// File: rtl/vga_rx_monitor.sv
// Observes hsync/vsync/rgb at the connector, recovers pixel coordinates, checks line/frame
// timing, reports lock, captures a probe pixel and an additive per-frame checksum.
module vga_rx_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic     clk_100MHz,
  input logic     reset,
  vga_rx_if.slave bus
);

  localparam logic [9:0] HTotal = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [9:0] VTotal = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [9:0] HStart = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HEnd   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] VStart = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VEnd   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] CntMax = '1;
  localparam logic [7:0] LockCnt = 8'(LOCK_FRAMES);

  logic        hs_prev_q, vs_prev_q;
  logic [9:0]  h_cnt_q, v_cnt_q;
  logic [9:0]  h_cnt_d, v_cnt_d;
  logic        h_arm_q, v_arm_q, line_bad_q;
  logic [7:0]  good_cnt_q;
  logic [31:0] acc_q;
  logic [9:0]  x_q, y_q, h_total_q, v_total_q;
  logic        video_on_q, locked_q, h_err_q, v_err_q, probe_vld_q, frame_done_q;
  logic [11:0] probe_rgb_q;
  logic [31:0] frame_sum_q;

  logic        hs_now, vs_now, hs_lead, vs_lead;
  logic        vid_d, h_bad, v_bad, frame_bad, probe_hit;
  logic [9:0]  x_d, y_d, h_meas, v_meas;
  logic [7:0]  good_inc;

  assign hs_now  = (bus.hsync == SYNC_ACTIVE);
  assign vs_now  = (bus.vsync == SYNC_ACTIVE);
  assign hs_lead = bus.p_tick && hs_now && !hs_prev_q;
  assign vs_lead = bus.p_tick && vs_now && !vs_prev_q;

  // vsync lead edge wins over a coincident hsync edge for the line counter.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (hs_lead) begin
      h_cnt_d = '0;
    end else if (bus.p_tick && h_cnt_q != CntMax) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
    if (vs_lead) begin
      v_cnt_d = '0;
    end else if (hs_lead && v_cnt_q != CntMax) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end
  end

  // Coordinates describe the sample taken on this tick, hence the next-state counters.
  assign vid_d = (h_cnt_d >= HStart) && (h_cnt_d < HEnd) &&
                 (v_cnt_d >= VStart) && (v_cnt_d < VEnd);
  assign x_d   = h_cnt_d - HStart;
  assign y_d   = v_cnt_d - VStart;

  assign h_meas    = h_cnt_q + 10'd1;
  assign v_meas    = v_cnt_q + 10'd1;
  assign h_bad     = (h_meas != HTotal);
  assign v_bad     = (v_meas != VTotal);
  // A bad line ending on the frame edge itself still belongs to the frame being closed.
  assign frame_bad = v_bad || line_bad_q || (hs_lead && h_arm_q && h_bad);
  assign good_inc  = (good_cnt_q >= LockCnt) ? good_cnt_q : good_cnt_q + 8'd1;
  assign probe_hit = bus.p_tick && vid_d && (x_d == bus.probe_x) && (y_d == bus.probe_y);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      h_arm_q      <= 1'b0;
      v_arm_q      <= 1'b0;
      line_bad_q   <= 1'b0;
      good_cnt_q   <= '0;
      acc_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      video_on_q   <= 1'b0;
      locked_q     <= 1'b0;
      h_err_q      <= 1'b0;
      v_err_q      <= 1'b0;
      h_total_q    <= '0;
      v_total_q    <= '0;
      probe_rgb_q  <= '0;
      probe_vld_q  <= 1'b0;
      frame_sum_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      probe_vld_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.p_tick) begin
        hs_prev_q  <= hs_now;
        vs_prev_q  <= vs_now;
        h_cnt_q    <= h_cnt_d;
        v_cnt_q    <= v_cnt_d;
        video_on_q <= vid_d;
        x_q        <= x_d;
        y_q        <= y_d;
        if (vs_lead) begin
          acc_q <= '0;
        end else if (vid_d) begin
          acc_q <= acc_q + {20'b0, bus.rgb};
        end
        if (probe_hit) begin
          probe_rgb_q <= bus.rgb;
          probe_vld_q <= 1'b1;
        end
      end
      if (hs_lead) begin
        h_arm_q <= 1'b1;
        if (h_arm_q) begin
          h_total_q <= h_meas;
          if (h_bad) begin
            h_err_q    <= 1'b1;
            line_bad_q <= 1'b1;
          end
        end
      end
      // The first vsync edge after reset closes a partial frame and is not evaluated.
      if (vs_lead) begin
        v_arm_q <= 1'b1;
        if (v_arm_q) begin
          v_total_q    <= v_meas;
          frame_sum_q  <= acc_q;
          frame_done_q <= 1'b1;
          line_bad_q   <= 1'b0;
          if (v_bad) begin
            v_err_q <= 1'b1;
          end
          if (frame_bad) begin
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
          end else begin
            good_cnt_q <= good_inc;
            if (good_inc >= LockCnt) begin
              locked_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.video_on   = video_on_q;
  assign bus.locked     = locked_q;
  assign bus.h_err      = h_err_q;
  assign bus.v_err      = v_err_q;
  assign bus.h_total    = h_total_q;
  assign bus.v_total    = v_total_q;
  assign bus.probe_rgb  = probe_rgb_q;
  assign bus.probe_vld  = probe_vld_q;
  assign bus.frame_sum  = frame_sum_q;
  assign bus.frame_done = frame_done_q;

endmodule
